// File: rtl/rbcp_pkg.sv
// rtl/rbcp_pkg.sv - shared constants for the RBCP register bridge
//
// Holds the bridge FSM state encoding, the request operation codes and the
// register data width shared with the SIO slave bench.
package rbcp_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/rbcp_bus_bridge.sv
// rtl/rbcp_bus_bridge.sv - RBCP register strobes to single-beat local bus
//
// Executes each REG_WE/REG_RE request from the SiTCP serial-IO slave as one
// BUS_WR/BUS_RD beat and returns REG_ACK/REG_RV/REG_RD.
// Ports:
//   BUS_CLK, BUS_RST            clock, synchronous active-high reset
//   REG_ADDR/WD/WE/RE           request from the slave
//   REG_ACK/RV/RD               completion back to the slave
//   BUS_ADD/DATA_OUT/DATA_IN    local register bus address and data
//   BUS_WR/BUS_RD               one-cycle bus strobes
//   BUSY, DROP_CNT              in-flight flag, saturating ignored-request count
module rbcp_bus_bridge
  import rbcp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter logic [31:0] ADDR_HIGH      = 32'h0000_FFFF,
  parameter int          BUS_ADDR_WIDTH = 16,
  parameter int          READ_LATENCY   = 1
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST,
  input  logic [31:0]               REG_ADDR,
  input  logic [DATA_W-1:0]         REG_WD,
  input  logic                      REG_WE,
  input  logic                      REG_RE,
  output logic                      REG_ACK,
  output logic                      REG_RV,
  output logic [DATA_W-1:0]         REG_RD,
  output logic [BUS_ADDR_WIDTH-1:0] BUS_ADD,
  output logic [DATA_W-1:0]         BUS_DATA_OUT,
  input  logic [DATA_W-1:0]         BUS_DATA_IN,
  output logic                      BUS_WR,
  output logic                      BUS_RD,
  output logic                      BUSY,
  output logic [7:0]                DROP_CNT
);

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t     state;
  logic [3:0] wait_cnt;

  // A 33-bit subtraction gives both the translated address and the
  // below-base flag (borrow bit) without a constant compare when base is 0.
  logic [32:0] offset;
  logic        offset_unused;
  logic        in_range;
  logic        req;
  logic        op;

  assign offset        = {1'b0, REG_ADDR} - {1'b0, ADDR_BASE};
  assign offset_unused = ^offset;
  assign in_range      = !offset[32] && (REG_ADDR <= ADDR_HIGH);
  assign req           = REG_WE | REG_RE;
  // Simultaneous WE and RE resolve to a write.
  assign op            = REG_WE ? OP_WR : OP_RD;
  assign BUSY          = (state != IDLE);

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      REG_ACK      <= 1'b0;
      REG_RV       <= 1'b0;
      REG_RD       <= '0;
      BUS_ADD      <= '0;
      BUS_DATA_OUT <= '0;
      BUS_WR       <= 1'b0;
      BUS_RD       <= 1'b0;
      DROP_CNT     <= 8'd0;
    end else begin
      BUS_WR  <= 1'b0;
      BUS_RD  <= 1'b0;
      REG_ACK <= 1'b0;
      REG_RV  <= 1'b0;

      if (req && state != IDLE && DROP_CNT != 8'hFF) begin
        DROP_CNT <= DROP_CNT + 8'd1;
      end

      case (state)
        IDLE: begin
          if (req) begin
            if (in_range) begin
              BUS_ADD <= offset[BUS_ADDR_WIDTH-1:0];
              if (op == OP_WR) begin
                state        <= WRITE;
                BUS_WR       <= 1'b1;
                BUS_DATA_OUT <= REG_WD;
              end else begin
                state  <= READ;
                BUS_RD <= 1'b1;
              end
            end else begin
              // Out-of-window: acknowledge immediately with no bus activity.
              state   <= ACK;
              REG_ACK <= 1'b1;
            end
          end
        end
        WRITE: begin
          state   <= ACK;
          REG_ACK <= 1'b1;
        end
        READ: begin
          wait_cnt <= LAT;
          state    <= RWAIT;
        end
        RWAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          // Counter reaches zero this cycle: bus data is valid now.
          if (wait_cnt == 4'd1) begin
            REG_RD  <= BUS_DATA_IN;
            REG_ACK <= 1'b1;
            REG_RV  <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbcp_bus_bridge.sv
// tb/tb_rbcp_bus_bridge.sv - scoreboard bench for rbcp_bus_bridge
module tb_rbcp_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst[2];
  logic [31:0] reg_addr[2];
  logic [7:0]  reg_wd[2];
  logic        reg_we[2];
  logic        reg_re[2];
  logic        reg_ack[2];
  logic        reg_rv[2];
  logic [7:0]  reg_rd[2];
  logic [15:0] bus_add[2];
  logic [7:0]  bus_data_out[2];
  logic [7:0]  bus_data_in[2];
  logic        bus_wr[2];
  logic        bus_rd[2];
  logic        busy[2];
  logic [7:0]  drop_cnt[2];

  rbcp_bus_bridge dut0 (
    .BUS_CLK(clk), .BUS_RST(rst[0]),
    .REG_ADDR(reg_addr[0]), .REG_WD(reg_wd[0]), .REG_WE(reg_we[0]), .REG_RE(reg_re[0]),
    .REG_ACK(reg_ack[0]), .REG_RV(reg_rv[0]), .REG_RD(reg_rd[0]),
    .BUS_ADD(bus_add[0]), .BUS_DATA_OUT(bus_data_out[0]), .BUS_DATA_IN(bus_data_in[0]),
    .BUS_WR(bus_wr[0]), .BUS_RD(bus_rd[0]), .BUSY(busy[0]), .DROP_CNT(drop_cnt[0])
  );

  rbcp_bus_bridge #(
    .ADDR_BASE(32'h0000_0100), .ADDR_HIGH(32'h0000_01FF),
    .BUS_ADDR_WIDTH(16), .READ_LATENCY(4)
  ) dut1 (
    .BUS_CLK(clk), .BUS_RST(rst[1]),
    .REG_ADDR(reg_addr[1]), .REG_WD(reg_wd[1]), .REG_WE(reg_we[1]), .REG_RE(reg_re[1]),
    .REG_ACK(reg_ack[1]), .REG_RV(reg_rv[1]), .REG_RD(reg_rd[1]),
    .BUS_ADD(bus_add[1]), .BUS_DATA_OUT(bus_data_out[1]), .BUS_DATA_IN(bus_data_in[1]),
    .BUS_WR(bus_wr[1]), .BUS_RD(bus_rd[1]), .BUSY(busy[1]), .DROP_CNT(drop_cnt[1])
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic       rv;
    logic [7:0] rd;
  } resp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] add;
    logic [7:0]  data;
  } bev_t;

  resp_t      rq[2][$];
  bev_t       bq[2][$];
  logic [7:0] bus_rdata[2];
  logic [7:0] last_rd[2];
  int         due[2];

  function automatic int rl(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic push_resp(int i, int c, logic rv, logic [7:0] rd);
    resp_t r;
    r.cyc = c; r.rv = rv; r.rd = rd;
    rq[i].push_back(r);
  endtask

  task automatic push_bus(int i, int c, logic wr, logic [15:0] add, logic [7:0] data);
    bev_t b;
    b.cyc = c; b.wr = wr; b.add = add; b.data = data;
    bq[i].push_back(b);
  endtask

  // Bus slave: read data is valid only in cycle BUS_RD + latency.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus_rd[i]) due[i] = cyc + rl(i);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      bus_data_in[i] = (cyc == due[i]) ? bus_rdata[i] : 8'hEE;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or strobe.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reg_ack[i]) begin
        if (rq[i].size() == 0) begin
          flag($sformatf("dut%0d unexpected REG_ACK", i));
        end else begin
          resp_t e;
          e = rq[i].pop_front();
          chk($sformatf("dut%0d ack_cycle", i), cyc, e.cyc);
          chk($sformatf("dut%0d reg_rv", i), int'(reg_rv[i]), int'(e.rv));
          chk($sformatf("dut%0d reg_rd", i), int'(reg_rd[i]), int'(e.rd));
        end
      end else if (reg_rv[i]) begin
        flag($sformatf("dut%0d REG_RV without REG_ACK", i));
      end
      if (bus_wr[i] && bus_rd[i]) begin
        flag($sformatf("dut%0d BUS_WR and BUS_RD together", i));
      end else if (bus_wr[i] || bus_rd[i]) begin
        if (bq[i].size() == 0) begin
          flag($sformatf("dut%0d unexpected bus strobe", i));
        end else begin
          bev_t b;
          b = bq[i].pop_front();
          chk($sformatf("dut%0d bus_cycle", i), cyc, b.cyc);
          chk($sformatf("dut%0d bus_wr", i), int'(bus_wr[i]), int'(b.wr));
          chk($sformatf("dut%0d bus_add", i), int'(bus_add[i]), int'(b.add));
          if (b.wr) chk($sformatf("dut%0d bus_data_out", i), int'(bus_data_out[i]), int'(b.data));
        end
      end
    end
  end

  // kind: 0 out-of-range, 1 bus write, 2 bus read
  task automatic issue(int i, logic we, logic re, logic [31:0] addr, logic [7:0] wd,
                       int kind, logic [15:0] exp_add, logic exp_ack);
    int k;
    k = cyc;
    reg_addr[i] = addr;
    reg_wd[i]   = wd;
    reg_we[i]   = we;
    reg_re[i]   = re;
    if (kind == 1) begin
      push_bus(i, k + 1, 1'b1, exp_add, wd);
      if (exp_ack) push_resp(i, k + 2, 1'b0, last_rd[i]);
    end else if (kind == 2) begin
      push_bus(i, k + 1, 1'b0, exp_add, 8'h00);
      if (exp_ack) begin
        last_rd[i] = bus_rdata[i];
        push_resp(i, k + 2 + rl(i), 1'b1, bus_rdata[i]);
      end
    end else begin
      push_resp(i, k + 1, 1'b0, last_rd[i]);
    end
    @(posedge clk); #1;
    reg_we[i] = 1'b0;
    reg_re[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while ((rq[i].size() != 0 || bq[i].size() != 0 || busy[i]) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (rq[i].size() != 0 || bq[i].size() != 0 || busy[i]) begin
      flag($sformatf("dut%0d completion timeout", i));
      rq[i].delete();
      bq[i].delete();
    end
  endtask

  task automatic chk_zero(int i, string tag);
    chk($sformatf("%s dut%0d ack", tag, i), int'(reg_ack[i]), 0);
    chk($sformatf("%s dut%0d rv", tag, i), int'(reg_rv[i]), 0);
    chk($sformatf("%s dut%0d rd", tag, i), int'(reg_rd[i]), 0);
    chk($sformatf("%s dut%0d bus_add", tag, i), int'(bus_add[i]), 0);
    chk($sformatf("%s dut%0d bus_data_out", tag, i), int'(bus_data_out[i]), 0);
    chk($sformatf("%s dut%0d bus_wr", tag, i), int'(bus_wr[i]), 0);
    chk($sformatf("%s dut%0d bus_rd", tag, i), int'(bus_rd[i]), 0);
    chk($sformatf("%s dut%0d busy", tag, i), int'(busy[i]), 0);
    chk($sformatf("%s dut%0d drop_cnt", tag, i), int'(drop_cnt[i]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; reg_addr[i] = '0; reg_wd[i] = '0; reg_we[i] = 1'b0; reg_re[i] = 1'b0;
      bus_rdata[i] = 8'h00; last_rd[i] = 8'h00; due[i] = -1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_zero(0, "reset");
    chk_zero(1, "reset");

    // Write then reads on the default window, latency 1.
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 8'hA5, 1, 16'h0010, 1'b1);
    wait_idle(0);
    bus_rdata[0] = 8'h3C;
    issue(0, 1'b0, 1'b1, 32'h0000_0010, 8'h00, 2, 16'h0010, 1'b1);
    wait_idle(0);
    bus_rdata[0] = 8'h81;
    issue(0, 1'b0, 1'b1, 32'h0000_FFFF, 8'h00, 2, 16'hFFFF, 1'b1);
    wait_idle(0);
    issue(0, 1'b0, 1'b1, 32'h0001_0000, 8'h00, 0, 16'h0000, 1'b1);
    wait_idle(0);
    issue(0, 1'b1, 1'b0, 32'h0001_0000, 8'h12, 0, 16'h0000, 1'b1);
    wait_idle(0);
    issue(0, 1'b0, 1'b1, 32'h8000_0000, 8'h00, 0, 16'h0000, 1'b1);
    wait_idle(0);
    issue(0, 1'b1, 1'b0, 32'h0000_0000, 8'h5E, 1, 16'h0000, 1'b1);
    wait_idle(0);

    // Offset window 0x100..0x1FF, latency 4.
    bus_rdata[1] = 8'hC3;
    issue(1, 1'b0, 1'b1, 32'h0000_01FF, 8'h00, 2, 16'h00FF, 1'b1);
    wait_idle(1);
    bus_rdata[1] = 8'h5A;
    issue(1, 1'b0, 1'b1, 32'h0000_0100, 8'h00, 2, 16'h0000, 1'b1);
    wait_idle(1);
    issue(1, 1'b0, 1'b1, 32'h0000_0200, 8'h00, 0, 16'h0000, 1'b1);
    wait_idle(1);
    issue(1, 1'b1, 1'b0, 32'h0000_00FF, 8'h99, 0, 16'h0000, 1'b1);
    wait_idle(1);
    issue(1, 1'b1, 1'b0, 32'h0000_0150, 8'h11, 1, 16'h0050, 1'b1);
    wait_idle(1);
    issue(1, 1'b0, 1'b1, 32'h8000_0150, 8'h00, 0, 16'h0000, 1'b1);
    wait_idle(1);
    chk("dut1 drop_cnt idle", int'(drop_cnt[1]), 0);

    // Writes strobed while the read is in flight are dropped.
    bus_rdata[0] = 8'h66;
    issue(0, 1'b0, 1'b1, 32'h0000_0040, 8'h00, 2, 16'h0040, 1'b1);
    reg_we[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reg_we[0] = 1'b0;
    wait_idle(0);
    chk("dut0 drop_cnt two", int'(drop_cnt[0]), 2);

    // Continuous read strobe: one accepted, three dropped per transaction.
    bus_rdata[0] = 8'h77;
    for (int n = 0; n < 100; n++) begin
      int k;
      if (n == 20) chk("dut0 drop_cnt 62", int'(drop_cnt[0]), 62);
      k = cyc;
      reg_addr[0] = 32'h0000_0030;
      reg_re[0]   = 1'b1;
      push_bus(0, k + 1, 1'b0, 16'h0030, 8'h00);
      last_rd[0] = 8'h77;
      push_resp(0, k + 3, 1'b1, 8'h77);
      repeat (4) begin
        @(posedge clk); #1;
      end
    end
    reg_re[0] = 1'b0;
    wait_idle(0);
    chk("dut0 drop_cnt saturated", int'(drop_cnt[0]), 255);

    // Reset in the RWAIT cycle discards the read.
    bus_rdata[0] = 8'h99;
    issue(0, 1'b0, 1'b1, 32'h0000_0010, 8'h00, 2, 16'h0010, 1'b0);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    last_rd[0] = 8'h00;
    chk_zero(0, "midreset");
    issue(0, 1'b1, 1'b0, 32'h0000_0012, 8'h44, 1, 16'h0012, 1'b1);
    wait_idle(0);

    // WE+RE together is a write; back-to-back strobe right after ACK.
    k0 = cyc;
    issue(0, 1'b1, 1'b1, 32'h0000_0020, 8'hB7, 1, 16'h0020, 1'b1);
    wait_idle(0);
    chk("dut0 back_to_back cycle", cyc, k0 + 3);
    issue(0, 1'b1, 1'b0, 32'h0000_0022, 8'h3D, 1, 16'h0022, 1'b1);
    wait_idle(0);
    chk("dut0 drop_cnt after b2b", int'(drop_cnt[0]), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("dut0 leftover resp", rq[0].size(), 0);
    chk("dut1 leftover resp", rq[1].size(), 0);
    chk("dut0 leftover bus", bq[0].size(), 0);
    chk("dut1 leftover bus", bq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbcp_bus_bridge.md
Name: rbcp_bus_bridge

Overview:
- Consumes the register strobes (REG_WE/REG_RE/REG_ADDR/REG_WD) produced by the SiTCP serial-IO slave.
- Executes each access as a single-beat transfer on the local BUS_CLK register bus (BUS_ADD/BUS_WR/BUS_RD).
- Returns REG_ACK/REG_RV/REG_RD to the slave, which serialises them back to the host.
- Handles address-window checking, base-offset translation, fixed read latency and dropped-request accounting.

Parameters:
- ADDR_BASE, 32'h0000_0000, lowest REG_ADDR mapped to the bus (inclusive).
- ADDR_HIGH, 32'h0000_FFFF, highest REG_ADDR mapped to the bus (inclusive).
- BUS_ADDR_WIDTH, 16, width of BUS_ADD.
- READ_LATENCY, 1, BUS_CLK cycles from the BUS_RD cycle to valid BUS_DATA_IN; legal range 1..15.

Ports:
- BUS_CLK  in  1  sole clock; all REG_* inputs are synchronous to it.
- BUS_RST  in  1  synchronous, active-high reset.
- REG_ADDR  in  32  request address.
- REG_WD  in  8  write data.
- REG_WE  in  1  one-cycle write request strobe.
- REG_RE  in  1  one-cycle read request strobe.
- REG_ACK  out  1  one-cycle completion strobe.
- REG_RV  out  1  read valid; high only together with REG_ACK on a successful read.
- REG_RD  out  8  read data; meaningful when REG_RV=1.
- BUS_ADD  out  BUS_ADDR_WIDTH  translated bus address.
- BUS_DATA_OUT  out  8  bus write data.
- BUS_DATA_IN  in  8  bus read data.
- BUS_WR  out  1  one-cycle bus write strobe.
- BUS_RD  out  1  one-cycle bus read strobe.
- BUSY  out  1  high while a transaction is in flight (FSM not in IDLE).
- DROP_CNT  out  8  saturating count of requests ignored while busy.

Behaviour:
Reset:
- While BUS_RST=1 at a clock edge, all outputs go to 0, FSM goes to IDLE and DROP_CNT clears.
- A transaction in flight at reset is discarded; no REG_ACK is ever issued for it.

FSM states: IDLE, WRITE, READ, RWAIT, ACK.
- IDLE:
  - On REG_WE or REG_RE, latch REG_ADDR/REG_WD and the operation type.
  - If REG_WE and REG_RE are high together, the request is a write and the read is dropped without counting.
  - In-range (ADDR_BASE <= REG_ADDR <= ADDR_HIGH, unsigned 32-bit compare): go to WRITE or READ.
  - Out-of-range: go to ACK with RV=0.
- WRITE: BUS_WR=1 and BUS_DATA_OUT=latched WD for exactly one cycle, then go to ACK (RV=0).
- READ: BUS_RD=1 for exactly one cycle, load the wait counter with READ_LATENCY, then go to RWAIT.
- RWAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 0 (cycle BUS_RD+READ_LATENCY), capture BUS_DATA_IN into REG_RD, set RV pending and go to ACK.
- ACK: REG_ACK=1 for one cycle, REG_RV=pending RV, then return to IDLE.

Bus signals and outputs:
- BUS_ADD = (latched REG_ADDR - ADDR_BASE)[BUS_ADDR_WIDTH-1:0].
- BUS_ADD is driven from the WRITE/READ cycle and held until the next transaction.
- BUS_DATA_OUT holds its value outside writes.
- BUS_WR and BUS_RD are never high together and never high in any state other than WRITE/READ.
- REG_RD holds its last captured value between reads. REG_RV=0 whenever REG_ACK=0.

Latency, with the request strobe in cycle 0:
- In-range write: BUS_WR in cycle 1, REG_ACK in cycle 2.
- In-range read: BUS_RD in cycle 1, data capture in cycle 1+READ_LATENCY, REG_ACK in cycle 2+READ_LATENCY.
- Out-of-range: REG_ACK in cycle 1 with RV=0 and no bus strobe; the slave converts this to 0xFF.

Busy handling:
- BUSY = (state != IDLE).
- A REG_WE/REG_RE arriving while BUSY, including in the ACK cycle, is ignored and DROP_CNT increments.
- DROP_CNT saturates at 255 and clears only on reset.
- A strobe arriving in the first IDLE cycle after ACK is accepted normally (back-to-back support).

Address boundaries:
- ADDR_BASE and ADDR_HIGH themselves are in-range.
- ADDR_HIGH+1 and ADDR_BASE-1 are out-of-range; ADDR_BASE-1 does not apply when ADDR_BASE=0.
- Subtraction never wraps for in-range addresses.

Decomposition:
- Shared package rbcp_pkg holds:
  - the FSM state encoding constants (IDLE, WRITE, READ, RWAIT, ACK);
  - the op-type constants (OP_WR, OP_RD);
  - the 8-bit data width constant, reused by the SIO slave bench.
- No sub-module is needed; the wait counter and range check stay inline.

Test Plan:
1. Reset, then write REG_ADDR=0x0000_0010, REG_WD=0xA5 -> BUS_WR in cycle 1 with BUS_ADD=0x0010 and BUS_DATA_OUT=0xA5; REG_ACK=1, REG_RV=0 in cycle 2.
2. Read 0x0000_0010 with READ_LATENCY=1, bus model returning 0x3C -> BUS_RD in cycle 1; REG_ACK=1, REG_RV=1, REG_RD=0x3C in cycle 3. Repeat with READ_LATENCY=4 -> ACK in cycle 6.
3. ADDR_BASE=0x100, ADDR_HIGH=0x1FF: read 0x1FF -> BUS_ADD=0xFF, RV=1; read 0x200 -> no BUS_RD, REG_ACK in cycle 1, RV=0; write 0xFF -> no BUS_WR, REG_ACK in cycle 1.
4. Read issued, then REG_WE pulsed in cycles 1 and 2 -> both ignored, DROP_CNT=2, only one ACK. After 300 ignored strobes -> DROP_CNT=255.
5. Assert BUS_RST in the RWAIT cycle -> no REG_ACK follows, all outputs 0; a new write immediately after completes normally in 2 cycles.
6. REG_WE and REG_RE high together at 0x0020 -> one BUS_WR, no BUS_RD, one ACK with RV=0. A back-to-back write strobed in the cycle after ACK is accepted, with DROP_CNT unchanged.
